// File: rtl/hart_scheduler.sv
// Round-robin fetch scheduler for a multithreaded core: per-hart OFF/READY/WAIT state and a registered
// issue selection that starts its search at the hart after the last one issued.
module hart_scheduler #(
  parameter int NUM_HARTS = 4,
  parameter int HART_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NUM_HARTS-1:0] hart_enable,
  input  logic                 block_req,
  input  logic [HART_W-1:0]    block_hart,
  input  logic [NUM_HARTS-1:0] wake,
  output logic                 issue_valid,
  output logic [HART_W-1:0]    issue_hart,
  output logic [31:0]          hart_id,
  output logic [NUM_HARTS-1:0] ready_mask,
  output logic [15:0]          idle_cycles
);

  localparam int SLOTS = 1 << HART_W;

  typedef enum logic [1:0] {
    H_OFF   = 2'd0,
    H_READY = 2'd1,
    H_WAIT  = 2'd2
  } hstate_t;

  hstate_t              state     [NUM_HARTS];
  hstate_t              state_nxt [NUM_HARTS];
  logic [NUM_HARTS-1:0] blocked;
  logic [SLOTS-1:0]     eligible;
  logic [HART_W-1:0]    last;
  logic [HART_W-1:0]    pick;
  logic                 found;
  int                   cand;

  // A block only counts when it actually moves a READY hart to WAIT; a
  // simultaneous wake cancels it and the hart stays eligible.
  always_comb begin
    blocked  = '0;
    eligible = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      state_nxt[h] = state[h];
      blocked[h]   = block_req && (block_hart == HART_W'(h)) && !wake[h] &&
                     (state[h] == H_READY);
      if (!hart_enable[h]) begin
        state_nxt[h] = H_OFF;
      end else begin
        case (state[h])
          H_OFF:   state_nxt[h] = H_READY;
          H_READY: if (blocked[h]) state_nxt[h] = H_WAIT;
          H_WAIT:  if (wake[h]) state_nxt[h] = H_READY;
          default: state_nxt[h] = H_OFF;
        endcase
      end
      eligible[h] = (state[h] == H_READY) && hart_enable[h] && !blocked[h];
    end
  end

  // Search last+1 .. last+NUM_HARTS (mod NUM_HARTS); last itself is the final candidate.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = 0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_HARTS) cand = cand - NUM_HARTS;
      if (!found && eligible[HART_W'(cand)]) begin
        found = 1'b1;
        pick  = HART_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NUM_HARTS; h++) state[h] <= H_OFF;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) state[h] <= state_nxt[h];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_hart  <= '0;
      last        <= HART_W'(NUM_HARTS - 1);
      idle_cycles <= '0;
    end else if (!stall) begin
      if (found) begin
        issue_valid <= 1'b1;
        issue_hart  <= pick;
        last        <= pick;
      end else begin
        issue_valid <= 1'b0;
        if (idle_cycles != 16'hFFFF) idle_cycles <= idle_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    ready_mask = '0;
    for (int h = 0; h < NUM_HARTS; h++) ready_mask[h] = (state[h] == H_READY);
  end

  assign hart_id = {{(32 - HART_W){1'b0}}, issue_hart};

endmodule

// File: tb/tb_hart_scheduler.sv
// Directed stimulus for hart_scheduler; expected issue harts are queued and a negedge monitor checks them.
module tb_hart_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [3:0]  hart_enable;
  logic        block_req;
  logic [1:0]  block_hart;
  logic [3:0]  wake;
  logic        issue_valid;
  logic [1:0]  issue_hart;
  logic [31:0] hart_id;
  logic [3:0]  ready_mask;
  logic [15:0] idle_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  hart_scheduler #(.NUM_HARTS(4), .HART_W(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .hart_enable(hart_enable),
    .block_req(block_req), .block_hart(block_hart), .wake(wake),
    .issue_valid(issue_valid), .issue_hart(issue_hart), .hart_id(hart_id),
    .ready_mask(ready_mask), .idle_cycles(idle_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented issue consumes one queued expectation.
  always @(negedge clk) begin
    if (!reset && issue_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got hart %0d, expected no issue", issue_hart);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("issue_hart", 32'(issue_hart), 32'(e));
        check("hart_id", hart_id, 32'(e));
      end
    end
  end

  // One clock edge; e >= 0 queues the hart expected to be presented after it.
  task automatic cyc(input int e);
    if (e >= 0) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_block(input int h, input int e);
    block_req  = 1'b1;
    block_hart = 2'(h);
    cyc(e);
    block_req  = 1'b0;
  endtask

  task automatic cyc_wake(input logic [3:0] w, input int e);
    wake = w;
    cyc(e);
    wake = 4'b0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_issue_valid"}, 32'(issue_valid), 32'd0);
    check({tag, "_issue_hart"}, 32'(issue_hart), 32'd0);
    check({tag, "_hart_id"}, hart_id, 32'd0);
    check({tag, "_ready_mask"}, 32'(ready_mask), 32'd0);
    check({tag, "_idle"}, 32'(idle_cycles), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    hart_enable = 4'b0000;
    block_req   = 1'b0;
    block_hart  = 2'd0;
    wake        = 4'b0000;
    repeat (2) cyc(-1);
    hart_enable = 4'b1111;
    cyc(-1);
    check_reset_outputs("rst");

    // First edge only wakes harts; issue starts on the second edge at hart 0.
    reset = 1'b0;
    cyc(-1);
    check("first_edge_valid", 32'(issue_valid), 32'd0);
    check("first_edge_mask", 32'(ready_mask), 32'hF);
    check("first_edge_idle", 32'(idle_cycles), 32'd1);
    cyc(0); cyc(1); cyc(2); cyc(3); cyc(0); cyc(1);

    // Block hart 2 while last=1: 3 is chosen, 2 drops out until woken.
    cyc_block(2, 3);
    check("block_mask", 32'(ready_mask), 32'hB);
    cyc(0); cyc(1); cyc(3); cyc(0);
    cyc_wake(4'b0100, 1);
    cyc(2); cyc(3); cyc(0);
    check("wake_mask", 32'(ready_mask), 32'hF);

    // Stall while issue_hart=2 holds the selection and the idle count.
    cyc(1); cyc(2);
    stall = 1'b1;
    cyc(2); cyc(2); cyc(2);
    check("stall_idle", 32'(idle_cycles), 32'd1);
    check("stall_valid", 32'(issue_valid), 32'd1);
    stall = 1'b0;
    cyc(3); cyc(0);

    // Block and wake to the same READY hart: it stays READY.
    cyc(1);
    wake = 4'b0010;
    cyc_block(1, 2);
    wake = 4'b0000;
    check("blk_wake_mask", 32'(ready_mask), 32'hF);
    cyc(3); cyc(0); cyc(1);

    // Disable wins over wake.
    hart_enable = 4'b1110;
    cyc_wake(4'b0001, 2);
    check("disable_mask", 32'(ready_mask), 32'hE);
    cyc(3); cyc(1); cyc(2);

    // Park hart 3 in WAIT; a second block to it is ignored.
    cyc_block(3, 1);
    check("wait3_mask", 32'(ready_mask), 32'h6);
    cyc_block(3, 2);
    check("wait3_reblock_mask", 32'(ready_mask), 32'h6);
    hart_enable = 4'b1111;
    cyc(1);
    check("reenable_mask", 32'(ready_mask), 32'h7);

    // Asynchronous reset mid-rotation, away from any edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(-1);
    check("rerst_mask", 32'(ready_mask), 32'hF);
    check("rerst_idle", 32'(idle_cycles), 32'd1);
    cyc(0); cyc(1); cyc(2); cyc(3);

    // Only hart 1 enabled, then blocked: idle counts up each cycle.
    hart_enable = 4'b0010;
    cyc(1);
    cyc_block(1, -1);
    check("idle_valid", 32'(issue_valid), 32'd0);
    check("idle_2", 32'(idle_cycles), 32'd2);
    cyc(-1);
    check("idle_3", 32'(idle_cycles), 32'd3);
    cyc(-1);
    check("idle_4", 32'(idle_cycles), 32'd4);
    cyc_wake(4'b0010, -1);
    cyc(1);
    check("idle_after_wake", 32'(idle_cycles), 32'd5);
    check("wake_issue_valid", 32'(issue_valid), 32'd1);

    // Long idle run: must saturate at 0xFFFF rather than wrap.
    cyc_block(1, -1);
    for (int i = 0; i < 65534; i++) cyc(-1);
    check("idle_sat", 32'(idle_cycles), 32'hFFFF);
    cyc(-1); cyc(-1);
    check("idle_sat_hold", 32'(idle_cycles), 32'hFFFF);

    @(negedge clk);
    #1;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hart_scheduler.md
HART_SCHEDULER -- requirements
Module: hart_scheduler

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 4, the number of hardware threads (2..8).
REQ-002 SHALL have parameter HART_W, default 2, the hart index width; NUM_HARTS SHALL be at most 2**HART_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port stall  input  1  fetch-stage stall; 1 freezes issue selection.
REQ-006 SHALL have port hart_enable  input  NUM_HARTS  per-hart software enable level.
REQ-007 SHALL have port block_req  input  1  pulse: put hart block_hart into WAIT (long-latency op issued).
REQ-008 SHALL have port block_hart  input  HART_W  target hart of block_req.
REQ-009 SHALL have port wake  input  NUM_HARTS  per-hart wake pulses (long-latency op complete).
REQ-010 SHALL have port issue_valid  output  1  a hart is selected for fetch this cycle.
REQ-011 SHALL have port issue_hart  output  HART_W  selected hart index.
REQ-012 SHALL have port hart_id  output  32  issue_hart zero-extended, driving the immediate generator hart-ID input.
REQ-013 SHALL have port ready_mask  output  NUM_HARTS  bit h = 1 when hart h is in READY.
REQ-014 SHALL have port idle_cycles  output  16  saturating count of unstalled cycles with no issue.

Function
REQ-015 Each hart SHALL have a registered state: OFF, READY or WAIT.
REQ-016 hart_enable[h]=0 SHALL force hart h to OFF next cycle from any state, overriding all other events.
REQ-017 OFF SHALL go to READY next cycle when hart_enable[h]=1.
REQ-018 READY SHALL go to WAIT when block_req=1 and block_hart=h, unless wake[h]=1 in the same cycle, in which case it stays READY.
REQ-019 WAIT SHALL go to READY when wake[h]=1; block_req to a hart already in WAIT SHALL be ignored.
REQ-020 wake[h] in OFF or READY (with no block) SHALL be ignored.
REQ-021 block_req with block_hart >= NUM_HARTS SHALL be ignored.
REQ-022 Hart h SHALL be eligible in a cycle when its state is READY, hart_enable[h]=1 and it is not the target of an accepted block_req that cycle.
REQ-023 With stall=0, the next issue_hart SHALL be the first eligible hart searching last+1, last+2, ... modulo NUM_HARTS, where last is the last-issued-hart register; the search includes last itself as final candidate.
REQ-024 With stall=0 and at least one eligible hart, issue_valid SHALL be 1 next cycle and last SHALL update to the chosen hart.
REQ-025 With stall=0 and no eligible hart, issue_valid SHALL be 0 next cycle, issue_hart and last SHALL hold, and idle_cycles SHALL increment, saturating at 0xFFFF.
REQ-026 With stall=1, issue_valid, issue_hart, last and idle_cycles SHALL hold; hart state transitions SHALL still occur.
REQ-027 Selection latency SHALL be one cycle: outputs are registered and reflect the states and inputs at the preceding edge.
REQ-028 hart_id SHALL equal {zeros, issue_hart} at all times; ready_mask SHALL be the combinational decode of the current states.

Reset
REQ-029 While reset=1, all harts SHALL be OFF, issue_valid=0, issue_hart=0, hart_id=0, ready_mask=0, idle_cycles=0, and last=NUM_HARTS-1, so hart 0 is first after reset.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge, discarding any pending WAIT states.
REQ-031 The first edge after reset release SHALL only move enabled harts OFF->READY; the first issue_valid=1 SHALL appear on the second edge.

Verification
REQ-032 Reset, then hart_enable=4'b1111, stall=0 -> issue_hart sequence 0,1,2,3,0,... with issue_valid=1 from the second edge.
REQ-033 All READY, last=1, block_req=1 with block_hart=2 -> next issue_hart=3, ready_mask=4'b1011; wake[2]=1 later -> hart 2 rejoins the rotation after 1.
REQ-034 Only hart 1 enabled and block_req to hart 1 -> issue_valid=0 and idle_cycles counts 1,2,3,...; wake[1] -> issue_hart=1 again; force idle_cycles to 0xFFFF -> it holds at 0xFFFF.
REQ-035 stall=1 for 3 cycles while issue_hart=2 -> issue_hart holds 2 and idle_cycles is unchanged; stall=0 -> next issue_hart=3.
REQ-036 block_req and wake for the same READY hart in one cycle -> hart stays READY; hart_enable[0]=0 with wake[0]=1 -> hart 0 goes OFF.
REQ-037 reset asserted mid-rotation with hart 3 in WAIT -> all outputs go to reset values asynchronously, and after release rotation restarts at hart 0.
